// File: rtl/pe_mac_sat.sv
// Systolic processing element: registered A/B pass-through, saturating MAC
// accumulator, and a counter-driven drain that emits the quantised result
// followed by POS upstream results along the drain daisy chain.
module pe_mac_sat #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned SIGNED    = 1,
    parameter int unsigned POS       = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              b_valid_i,
    output logic [DATA_W-1:0] a_o,
    output logic              a_valid_o,
    output logic [DATA_W-1:0] b_o,
    output logic              b_valid_o,
    input  logic              clear_i,
    input  logic              drain_start_i,
    input  logic [OUT_W-1:0]  d_i,
    input  logic              d_valid_i,
    output logic [OUT_W-1:0]  d_o,
    output logic              d_valid_o,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam int unsigned PROD_W    = 2 * DATA_W;
    localparam int unsigned EXT_W     = ACC_W + 2;
    localparam int unsigned CNT_W     = 8;
    localparam bit          IS_SIGNED = (SIGNED != 0);

    // Clamp bounds and rounding constant, all in the sign-safe EXT_W domain
    localparam logic [EXT_W-1:0] ONE     = EXT_W'(1);
    localparam logic [EXT_W-1:0] ACC_HI  = IS_SIGNED ? ((ONE << (ACC_W - 1)) - ONE)
                                                     : ((ONE << ACC_W) - ONE);
    localparam logic [EXT_W-1:0] ACC_LO  = IS_SIGNED ? ~((ONE << (ACC_W - 1)) - ONE) : '0;
    localparam logic [EXT_W-1:0] OUT_HI  = IS_SIGNED ? ((ONE << (OUT_W - 1)) - ONE)
                                                     : ((ONE << OUT_W) - ONE);
    localparam logic [EXT_W-1:0] OUT_LO  = IS_SIGNED ? ~((ONE << (OUT_W - 1)) - ONE) : '0;
    localparam logic [EXT_W-1:0] ROUND_C = (FRAC_BITS > 0)
                                         ? (ONE << ((FRAC_BITS > 0) ? (FRAC_BITS - 1) : 0))
                                         : '0;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic               r_ovf;
    logic               w_ovf_next;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_av;
    logic               r_bv;
    logic [OUT_W-1:0]   r_d;
    logic [OUT_W-1:0]   w_d_next;
    logic [OUT_W-1:0]   w_q;
    logic               r_dv;
    logic               w_dv_next;
    logic               r_busy;
    logic [PROD_W-1:0]  w_a_x;
    logic [PROD_W-1:0]  w_b_x;
    logic [PROD_W-1:0]  w_prod;
    logic [EXT_W-1:0]   w_prod_x;
    logic [EXT_W-1:0]   w_acc_x;
    logic [EXT_W-1:0]   w_sum;
    logic [EXT_W-1:0]   w_rnd_x;
    logic [EXT_W-1:0]   w_shr;
    logic               w_mac;
    logic               w_capture;

    // Operands extended to full product width so one multiplier serves both signednesses
    assign w_a_x    = {{DATA_W{IS_SIGNED & a_i[DATA_W-1]}}, a_i};
    assign w_b_x    = {{DATA_W{IS_SIGNED & b_i[DATA_W-1]}}, b_i};
    assign w_prod   = w_a_x * w_b_x;
    assign w_prod_x = {{(EXT_W - PROD_W){IS_SIGNED & w_prod[PROD_W-1]}}, w_prod};
    assign w_acc_x  = {{2{IS_SIGNED & r_acc[ACC_W-1]}}, r_acc};
    assign w_sum    = w_acc_x + w_prod_x;
    assign w_mac    = a_valid_i & b_valid_i;
    assign w_capture = (r_state == ST_ACC) & drain_start_i;

    // Next accumulator value: clear/MAC with saturation, frozen while draining
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf;
        if (r_state == ST_ACC) begin
            if (clear_i) begin
                w_acc_next = w_mac ? ACC_W'(w_prod_x) : '0;
                w_ovf_next = 1'b0;
            end else if (w_mac) begin
                if ($signed(w_sum) > $signed(ACC_HI)) begin
                    w_acc_next = ACC_W'(ACC_HI);
                    w_ovf_next = 1'b1;
                end else if ($signed(w_sum) < $signed(ACC_LO)) begin
                    w_acc_next = ACC_W'(ACC_LO);
                    w_ovf_next = 1'b1;
                end else begin
                    w_acc_next = ACC_W'(w_sum);
                end
            end
        end
    end

    // Round-half-up, scale down and clamp the captured value to OUT_W
    assign w_rnd_x = {{2{IS_SIGNED & w_acc_next[ACC_W-1]}}, w_acc_next} + ROUND_C;
    assign w_shr   = EXT_W'($signed(w_rnd_x) >>> FRAC_BITS);

    // Output-range saturation of the quantised result
    always_comb begin
        w_q = OUT_W'(w_shr);
        if ($signed(w_shr) > $signed(OUT_HI)) begin
            w_q = OUT_W'(OUT_HI);
        end else if ($signed(w_shr) < $signed(OUT_LO)) begin
            w_q = OUT_W'(OUT_LO);
        end
    end

    // Drain FSM next state, beat counter and drain-chain output
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_d_next     = '0;
        w_dv_next    = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (drain_start_i) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = CNT_W'(POS);
                    w_d_next     = w_q;
                    w_dv_next    = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_d_next  = d_i;
                w_dv_next = d_valid_i;
                if (r_cnt == '0) begin
                    w_state_next = ST_ACC;
                end else if (d_valid_i) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = ST_ACC;
                    end
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    // Operand pass-through to right/bottom neighbours, active in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a  <= '0;
            r_av <= 1'b0;
            r_b  <= '0;
            r_bv <= 1'b0;
        end else begin
            r_a  <= a_i;
            r_av <= a_valid_i;
            r_b  <= b_i;
            r_bv <= b_valid_i;
        end
    end

    // Accumulator and sticky overflow; capture empties the accumulator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_capture ? '0 : w_acc_next;
            r_ovf <= w_ovf_next;
        end
    end

    // FSM state register with registered drain outputs and busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ACC;
            r_cnt   <= '0;
            r_d     <= '0;
            r_dv    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_d     <= w_d_next;
            r_dv    <= w_dv_next;
            r_busy  <= (w_state_next == ST_DRAIN);
        end
    end

    assign a_o       = r_a;
    assign a_valid_o = r_av;
    assign b_o       = r_b;
    assign b_valid_o = r_bv;
    assign d_o       = r_d;
    assign d_valid_o = r_dv;
    assign busy_o    = r_busy;
    assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_pe_mac_sat.sv
// Bench for pe_mac_sat: two configurations share one stimulus stream and are
// checked every cycle against an integer-arithmetic model, plus literal values.
module tb_pe_mac_sat;

    localparam int NI = 2;
    localparam int ACCW = 32;
    localparam int OUTW = 16;
    localparam int P_SGN [NI] = '{1, 0};
    localparam int P_FB  [NI] = '{8, 0};
    localparam int P_POS [NI] = '{2, 0};

    logic clk = 1'b0;
    logic reset_n;
    logic [15:0] a_in, b_in, d_in;
    logic av_in, bv_in, clr_in, ds_in, dv_in;

    logic [15:0] o_a [NI];
    logic [15:0] o_b [NI];
    logic [15:0] o_d [NI];
    logic o_av [NI];
    logic o_bv [NI];
    logic o_dv [NI];
    logic o_busy [NI];
    logic o_ovf [NI];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pe_mac_sat #(.DATA_W(16), .ACC_W(32), .OUT_W(16), .FRAC_BITS(8), .SIGNED(1), .POS(2)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .a_i(a_in), .a_valid_i(av_in), .b_i(b_in), .b_valid_i(bv_in),
        .a_o(o_a[0]), .a_valid_o(o_av[0]), .b_o(o_b[0]), .b_valid_o(o_bv[0]),
        .clear_i(clr_in), .drain_start_i(ds_in), .d_i(d_in), .d_valid_i(dv_in),
        .d_o(o_d[0]), .d_valid_o(o_dv[0]), .busy_o(o_busy[0]), .ovf_o(o_ovf[0])
    );

    pe_mac_sat #(.DATA_W(16), .ACC_W(32), .OUT_W(16), .FRAC_BITS(0), .SIGNED(0), .POS(0)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_i(a_in), .a_valid_i(av_in), .b_i(b_in), .b_valid_i(bv_in),
        .a_o(o_a[1]), .a_valid_o(o_av[1]), .b_o(o_b[1]), .b_valid_o(o_bv[1]),
        .clear_i(clr_in), .drain_start_i(ds_in), .d_i(d_in), .d_valid_i(dv_in),
        .d_o(o_d[1]), .d_valid_o(o_dv[1]), .busy_o(o_busy[1]), .ovf_o(o_ovf[1])
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        longint      acc;
        bit          ovf;
        bit          drn;
        bit          dv;
        int          left;
        logic [15:0] d;
    } m_t;

    m_t m [NI];
    logic [15:0] m_a, m_b;
    logic m_av, m_bv;

    function automatic longint rng_hi(int w, int sg);
        return (sg != 0) ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    endfunction

    function automatic longint rng_lo(int w, int sg);
        return (sg != 0) ? -(longint'(1) << (w - 1)) : 0;
    endfunction

    function automatic longint clampv(longint v, longint lo, longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint prod(int i, logic [15:0] a, logic [15:0] b);
        if (P_SGN[i] != 0) return longint'($signed(a)) * longint'($signed(b));
        return longint'(a) * longint'(b);
    endfunction

    function automatic longint quant(int i, longint r);
        longint q = r;
        if (P_FB[i] > 0) q = (r + (longint'(1) << (P_FB[i] - 1))) >>> P_FB[i];
        return clampv(q, rng_lo(OUTW, P_SGN[i]), rng_hi(OUTW, P_SGN[i]));
    endfunction

    function automatic m_t zero_m();
        m_t z;
        z.acc = 0; z.ovf = 0; z.drn = 0; z.dv = 0; z.left = 0; z.d = '0;
        return z;
    endfunction

    function automatic m_t next_m(int i, m_t c);
        m_t n = c;
        longint p, s, nacc, lo, hi;
        bit mac;
        if (!c.drn) begin
            mac  = av_in && bv_in;
            p    = prod(i, a_in, b_in);
            hi   = rng_hi(ACCW, P_SGN[i]);
            lo   = rng_lo(ACCW, P_SGN[i]);
            nacc = c.acc;
            if (clr_in) begin
                nacc  = mac ? p : 0;
                n.ovf = 0;
            end else if (mac) begin
                s = c.acc + p;
                if (s > hi || s < lo) n.ovf = 1;
                nacc = clampv(s, lo, hi);
            end
            if (ds_in) begin
                n.d    = 16'(quant(i, nacc));
                n.dv   = 1;
                n.acc  = 0;
                n.drn  = 1;
                n.left = P_POS[i];
            end else begin
                n.d   = '0;
                n.dv  = 0;
                n.acc = nacc;
            end
        end else begin
            n.d  = d_in;
            n.dv = dv_in;
            if (dv_in && c.left > 0) n.left = c.left - 1;
            if (n.left == 0) n.drn = 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NI; i++) m[i] <= zero_m();
            m_a <= '0; m_b <= '0; m_av <= 1'b0; m_bv <= 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) m[i] <= next_m(i, m[i]);
            m_a <= a_in; m_b <= b_in; m_av <= av_in; m_bv <= bv_in;
        end
    end

    // ---------------- checking ----------------
    function automatic void chk(input string name, input int i, input longint got, input longint want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s dut%0d: got %0h want %0h", name, i, got, want);
    endfunction

    function automatic void compare_all();
        for (int i = 0; i < NI; i++) begin
            chk("a_o", i, longint'(o_a[i]), longint'(m_a));
            chk("a_valid_o", i, longint'(o_av[i]), longint'(m_av));
            chk("b_o", i, longint'(o_b[i]), longint'(m_b));
            chk("b_valid_o", i, longint'(o_bv[i]), longint'(m_bv));
            chk("d_o", i, longint'(o_d[i]), longint'(m[i].d));
            chk("d_valid_o", i, longint'(o_dv[i]), longint'(m[i].dv));
            chk("busy_o", i, longint'(o_busy[i]), longint'(m[i].drn));
            chk("ovf_o", i, longint'(o_ovf[i]), longint'(m[i].ovf));
        end
    endfunction

    task automatic step(input logic [15:0] a, input logic av, input logic [15:0] b, input logic bv,
                        input logic clr, input logic ds, input logic [15:0] d, input logic dv);
        a_in = a; av_in = av; b_in = b; bv_in = bv;
        clr_in = clr; ds_in = ds; d_in = d; dv_in = dv;
        @(negedge clk);
        compare_all();
    endtask

    task automatic mac(input logic [15:0] a, input logic [15:0] b);
        step(a, 1'b1, b, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic clr_mac(input logic [15:0] a, input logic [15:0] b);
        step(a, 1'b1, b, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    // Capture (optionally with a MAC), then feed beats 0x11, gap, 0x22 with busy-time operands
    task automatic drain_full(input logic [15:0] a, input logic [15:0] b, input logic av,
                              input logic [15:0] exp0, input logic [15:0] exp1);
        step(a, av, b, av, 1'b0, 1'b1, 16'h0, 1'b0);
        chk("cap_d", 0, longint'(o_d[0]), longint'(exp0));
        chk("cap_v", 0, longint'(o_dv[0]), 1);
        chk("cap_busy", 0, longint'(o_busy[0]), 1);
        chk("cap_d", 1, longint'(o_d[1]), longint'(exp1));
        chk("cap_v", 1, longint'(o_dv[1]), 1);
        step(16'h7fff, 1'b1, 16'h7fff, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0);
        chk("pos0_v_after", 1, longint'(o_dv[1]), 0);
        chk("pos0_busy_after", 1, longint'(o_busy[1]), 0);
        chk("gap0_busy", 0, longint'(o_busy[0]), 1);
        step(16'h7fff, 1'b1, 16'h7fff, 1'b1, 1'b0, 1'b0, 16'h0011, 1'b1);
        chk("fwd1_d", 0, longint'(o_d[0]), 16'h0011);
        chk("fwd1_busy", 0, longint'(o_busy[0]), 1);
        step(16'h7fff, 1'b1, 16'h7fff, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("fwd_gap_v", 0, longint'(o_dv[0]), 0);
        chk("fwd_gap_busy", 0, longint'(o_busy[0]), 1);
        step(16'h7fff, 1'b1, 16'h7fff, 1'b1, 1'b0, 1'b0, 16'h0022, 1'b1);
        chk("fwd2_d", 0, longint'(o_d[0]), 16'h0022);
        chk("fwd2_v", 0, longint'(o_dv[0]), 1);
        chk("fwd2_busy", 0, longint'(o_busy[0]), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        a_in = '0; b_in = '0; d_in = '0;
        av_in = 1'b0; bv_in = 1'b0; clr_in = 1'b0; ds_in = 1'b0; dv_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_d", 0, longint'(o_d[0]), 0);
        chk("rst_busy", 0, longint'(o_busy[0]), 0);
        chk("rst_ovf", 0, longint'(o_ovf[0]), 0);
        chk("rst_a", 0, longint'(o_a[0]), 0);
        compare_all();
        reset_n = 1'b1;

        // Basic accumulate 3 x 0x200*0x300 = 0x120000
        repeat (3) mac(16'h0200, 16'h0300);
        drain_full(16'h0, 16'h0, 1'b0, 16'h1200, 16'hffff);
        // Operands issued while draining did not reach dut0's accumulator
        drain_full(16'h0, 16'h0, 1'b0, 16'h0000, 16'hffff);

        // Signed extremes and rounding edges
        clr_mac(16'h8000, 16'h8000);
        drain_full(16'h0, 16'h0, 1'b0, 16'h7fff, 16'hffff);
        clr_mac(16'h0001, 16'h0180);
        drain_full(16'h0, 16'h0, 1'b0, 16'h0002, 16'h0180);
        clr_mac(16'h0001, 16'h017f);
        drain_full(16'h0, 16'h0, 1'b0, 16'h0001, 16'h017f);
        clr_mac(16'hffff, 16'h0180);
        drain_full(16'h0, 16'h0, 1'b0, 16'hffff, 16'hffff);
        clr_mac(16'h8000, 16'h7fff);
        drain_full(16'h0, 16'h0, 1'b0, 16'h8000, 16'hffff);

        // Accumulator saturation and sticky overflow
        step(16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        repeat (2) mac(16'h7fff, 16'h7fff);
        chk("ovf_2mac", 0, longint'(o_ovf[0]), 0);
        mac(16'h7fff, 16'h7fff);
        chk("ovf_3mac", 0, longint'(o_ovf[0]), 1);
        chk("ovf_3mac", 1, longint'(o_ovf[1]), 0);
        repeat (2) mac(16'h7fff, 16'h7fff);
        chk("ovf_5mac", 1, longint'(o_ovf[1]), 1);
        drain_full(16'h0, 16'h0, 1'b0, 16'h7fff, 16'hffff);
        chk("ovf_sticky", 0, longint'(o_ovf[0]), 1);
        chk("ovf_sticky", 1, longint'(o_ovf[1]), 1);
        step(16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("ovf_clr", 0, longint'(o_ovf[0]), 0);
        chk("ovf_clr", 1, longint'(o_ovf[1]), 0);
        drain_full(16'h0, 16'h0, 1'b0, 16'h0000, 16'h0000);

        // Simultaneous clear+MAC and drain+MAC
        clr_mac(16'd3, 16'd4);
        drain_full(16'd3, 16'd4, 1'b1, 16'h0000, 16'h0018);
        clr_mac(16'h0100, 16'h0100);
        mac(16'h0100, 16'h0100);
        clr_mac(16'h0300, 16'h0400);
        drain_full(16'h0, 16'h0, 1'b0, 16'h0c00, 16'hffff);
        clr_mac(16'h0300, 16'h0400);
        drain_full(16'h0300, 16'h0400, 1'b1, 16'h1800, 16'hffff);

        // Asynchronous reset while dut0 is draining
        step(16'h0055, 1'b1, 16'h0066, 1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
        step(16'h0055, 1'b1, 16'h0066, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("pre_rst_a", 0, longint'(o_a[0]), 16'h0055);
        chk("pre_rst_busy", 0, longint'(o_busy[0]), 1);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_a", i, longint'(o_a[i]), 0);
            chk("arst_av", i, longint'(o_av[i]), 0);
            chk("arst_b", i, longint'(o_b[i]), 0);
            chk("arst_d", i, longint'(o_d[i]), 0);
            chk("arst_dv", i, longint'(o_dv[i]), 0);
            chk("arst_busy", i, longint'(o_busy[i]), 0);
            chk("arst_ovf", i, longint'(o_ovf[i]), 0);
        end
        @(negedge clk);
        compare_all();
        reset_n = 1'b1;
        chk("post_rst_lat", 0, longint'(o_a[0]), 0);
        step(16'h1234, 1'b1, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("post_rst_a", 0, longint'(o_a[0]), 16'h1234);
        chk("post_rst_b", 1, longint'(o_b[1]), 16'h4321);
        repeat (2) step(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
